// File: rtl/alu_result_stage_if.sv
// Handshake and datapath bundle between the adder/subtractor, the ALU result
// stage and its consumer.
interface alu_result_stage_if #(
    parameter int SIZE = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [SIZE-1:0] in_sum;
    logic [SIZE-1:0] in_cout;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_result;
    logic [3:0]      out_flags;

    modport master (
        output in_valid, in_op, in_sum, in_cout, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_op, in_sum, in_cout, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: derives the result and {N,Z,C,V} from the adder sum and
// carry vectors, then registers them through a 2-entry skid buffer.
//
// state   | meaning
// S_EMPTY | main and skid registers empty
// S_ONE   | main register holds a beat, skid empty
// S_TWO   | main and skid registers both hold beats, in_ready low
module alu_result_stage #(
    parameter int SIZE = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    alu_result_stage_if.slave  bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q;
    logic [SIZE-1:0] main_result_q, skid_result_q;
    logic [3:0]      main_flags_q, skid_flags_q;
    logic            load_main, load_skid, skid_to_main;

    logic            flag_n, flag_z, flag_c, flag_v;
    logic [SIZE-1:0] beat_result;
    logic [3:0]      beat_flags;
    logic            accept, drain;
    logic            unused_cout;

    // Only the top two carries matter; the rest are folded away on purpose.
    assign unused_cout = &{1'b0, bus.in_cout};

    assign flag_c     = bus.in_cout[SIZE-1];
    assign flag_v     = bus.in_cout[SIZE-1] ^ bus.in_cout[SIZE-2];
    assign flag_n     = bus.in_sum[SIZE-1];
    assign flag_z     = (bus.in_sum == '0);
    assign beat_flags = {flag_n, flag_z, flag_c, flag_v};

    always_comb begin
        beat_result = bus.in_sum;
        case (bus.in_op)
            2'b10:   beat_result = {{(SIZE-1){1'b0}}, flag_n ^ flag_v};
            2'b11:   beat_result = {{(SIZE-1){1'b0}}, ~flag_c};
            default: beat_result = bus.in_sum;
        endcase
    end

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = (state_q != S_EMPTY) && bus.out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        load_main = 1'b1;
                        state_d   = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_d   = S_TWO;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so no new beat can arrive.
                    if (drain) begin
                        skid_to_main = 1'b1;
                        state_d      = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_TWO);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_result_q <= '0;
            main_flags_q  <= '0;
            skid_result_q <= '0;
            skid_flags_q  <= '0;
        end else begin
            if (skid_to_main) begin
                main_result_q <= skid_result_q;
                main_flags_q  <= skid_flags_q;
            end else if (load_main) begin
                main_result_q <= beat_result;
                main_flags_q  <= beat_flags;
            end
            if (load_skid) begin
                skid_result_q <= beat_result;
                skid_flags_q  <= beat_flags;
            end
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q != S_EMPTY);
    assign bus.out_result = main_result_q;
    assign bus.out_flags  = main_flags_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: flag/result vectors, backpressure,
// flush and mid-stream reset.
module tb_alu_result_stage;
    localparam int SIZE = 32;

    logic clk;
    logic rst_n;
    logic flush;
    int   checks;
    int   errors;

    alu_result_stage_if #(.SIZE(SIZE)) bus ();

    alu_result_stage #(.SIZE(SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input logic [31:0] sum, input logic [31:0] cout);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_sum   = sum;
        bus.in_cout  = cout;
    endtask

    // op, in_sum, in_cout, expected result, expected {N,Z,C,V}
    logic [1:0]  v_op   [8] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};
    logic [31:0] v_sum  [8] = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'h2, 32'h7FFF_FFFF, 32'h2, 32'h1234_5678};
    logic [31:0] v_cout [8] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                                32'h1, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    logic [31:0] v_res  [8] = '{32'h8000_0000, 32'h0, 32'h1, 32'h1,
                                32'h0, 32'h1, 32'h0, 32'h1234_5678};
    logic [3:0]  v_flg  [8] = '{4'b1001, 4'b0110, 4'b1000, 4'b1010,
                                4'b0000, 4'b0001, 4'b0011, 4'b0010};

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = 2'b00;
        bus.in_sum    = '0;
        bus.in_cout   = '0;
        bus.out_ready = 1'b1;

        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_result", 64'(bus.out_result), 64'd0);
        chk("rst_flags", 64'(bus.out_flags), 64'd0);

        // First beat offered on the first edge with reset released, then back to back.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(v_op[i], v_sum[i], v_cout[i]);
            tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i), 64'(bus.out_result), 64'(v_res[i]));
            chk($sformatf("vec%0d_flags", i), 64'(bus.out_flags), 64'(v_flg[i]));
            chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        chk("drain_empty", 64'(bus.out_valid), 64'd0);

        // Backpressure: A and B accepted, C held until the skid empties.
        bus.out_ready = 1'b0;
        offer(2'b00, 32'hA, 32'h0);
        tick();
        chk("bp_a_result", 64'(bus.out_result), 64'hA);
        chk("bp_a_in_ready", 64'(bus.in_ready), 64'd1);
        offer(2'b00, 32'hB, 32'h0);
        tick();
        chk("bp_b_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_b_hold_a", 64'(bus.out_result), 64'hA);
        offer(2'b00, 32'hC, 32'h0);
        tick();
        chk("bp_c_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_c_hold_a", 64'(bus.out_result), 64'hA);
        chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_out_b", 64'(bus.out_result), 64'hB);
        chk("bp_out_b_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_ready_rise", 64'(bus.in_ready), 64'd1);
        tick();
        chk("bp_out_c", 64'(bus.out_result), 64'hC);
        chk("bp_out_c_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_done_empty", 64'(bus.out_valid), 64'd0);

        // Flush with both entries full and a beat offered on the same edge.
        bus.out_ready = 1'b0;
        offer(2'b00, 32'hD, 32'h0);
        tick();
        offer(2'b00, 32'hE, 32'h0);
        tick();
        chk("fl_full_in_ready", 64'(bus.in_ready), 64'd0);
        offer(2'b00, 32'hF, 32'h0);
        flush = 1'b1;
        tick();
        chk("fl_out_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_in_ready", 64'(bus.in_ready), 64'd1);
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("fl_no_ghost", 64'(bus.out_valid), 64'd0);

        // Reset mid-stream with both entries full.
        bus.out_ready = 1'b0;
        offer(2'b00, 32'h11, 32'h0);
        tick();
        offer(2'b00, 32'h22, 32'h0);
        tick();
        chk("mr_full_in_ready", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        tick();
        chk("mr_out_valid", 64'(bus.out_valid), 64'd0);
        chk("mr_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mr_result", 64'(bus.out_result), 64'd0);
        chk("mr_flags", 64'(bus.out_flags), 64'd0);
        rst_n = 1'b1;
        offer(2'b00, 32'h1234, 32'h0);
        tick();
        chk("mr_first_valid", 64'(bus.out_valid), 64'd1);
        chk("mr_first_result", 64'(bus.out_result), 64'h1234);
        chk("mr_first_flags", 64'(bus.out_flags), 64'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("mr_hold_result", 64'(bus.out_result), 64'h1234);
        chk("mr_hold_valid", 64'(bus.out_valid), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter SIZE, default 32, the datapath width (legal range 2..64).
REQ-002 clk  input  1  sole clock; every register SHALL update on its rising edge only.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 flush  input  1  synchronous pipeline flush; active high.
REQ-005 in_valid  input  1  upstream beat valid.
REQ-006 in_ready  output  1  the stage can accept a beat.
REQ-007 in_op  input  2  operation: 00 ADD, 01 SUB, 10 SLT, 11 SLTU.
REQ-008 in_sum  input  SIZE  sum vector S from the ripple-carry adder/subtractor.
REQ-009 in_cout  input  SIZE  per-bit carry vector Cout from the adder/subtractor.
REQ-010 out_valid  output  1  result beat valid.
REQ-011 out_ready  input  1  downstream accepts the beat.
REQ-012 out_result  output  SIZE  final ALU result.
REQ-013 out_flags  output  4  {N, Z, C, V} for the beat.

Function
REQ-014 Upstream SHALL drive adder CTRL=1 for SUB, SLT and SLTU, and CTRL=0 for ADD; this stage SHALL NOT check that CTRL setting.
REQ-015 Flag and result derivation, per beat:
- C = in_cout[SIZE-1]
- V = in_cout[SIZE-1] ^ in_cout[SIZE-2]
- N = in_sum[SIZE-1]
- Z = (in_sum == 0)
REQ-016 Result per op:
- ADD/SUB: in_sum.
- SLT: zero-extended (N ^ V).
- SLTU: zero-extended (~C).
REQ-017 Flags SHALL always reflect the add/sub sum, including for SLT and SLTU.
REQ-018 A beat SHALL transfer in when in_valid && in_ready at a rising edge, and out when out_valid && out_ready at a rising edge.
REQ-019 Buffering SHALL be a 2-entry skid buffer: a main output register plus one skid register.
REQ-020 in_ready SHALL be driven directly by a register equal to "skid register empty", with no combinational path from out_ready.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge k SHALL be visible on the outputs after edge k when the main register is empty or draining.
REQ-022 Throughput SHALL be 1 beat per cycle while out_ready is held high.
REQ-023 When the main register is full, is not draining, and a beat is accepted, that beat SHALL be stored in the skid register and in_ready SHALL fall after the same edge.
REQ-024 When the main register drains and the skid register is full, the skid contents SHALL move to the main register and in_ready SHALL rise after that edge.
REQ-025 Beats SHALL leave in acceptance order; none SHALL be duplicated or dropped except by flush or reset.
REQ-026 While out_valid=1 and out_ready=0, out_result and out_flags SHALL hold stable.
REQ-027 A simultaneous input accept and output drain on the same edge SHALL be legal, with occupancy unchanged.
REQ-028 flush=1 at an edge SHALL empty both entries and discard any beat offered on that edge; flush SHALL take priority over every transfer.
REQ-029 There SHALL be no combinational path from in_* to out_*.

Reset
REQ-030 rst_n=0 at an edge SHALL set out_valid=0, in_ready=1, out_result=0 and out_flags=0, and SHALL empty the skid register.
REQ-031 Reset SHALL override flush and all transfers; reset asserted mid-stream SHALL discard every buffered beat.
REQ-032 The first acceptance SHALL be possible on the first edge with rst_n=1.

Verification
REQ-033 ADD, in_sum=0x80000000, in_cout=0x7FFFFFFF -> out_result=0x80000000, flags N=1 Z=0 C=0 V=1.
REQ-034 SUB 5-5, in_sum=0, in_cout=0xFFFFFFFF -> out_result=0, flags N=0 Z=1 C=1 V=0.
REQ-035 Compare ops:
- SLTU 3 vs 5 (in_sum=0xFFFFFFFE, cout[31]=0) -> out_result=1.
- SLT -1 vs 1 (in_sum=0xFFFFFFFE, V=0) -> out_result=1.
- SLT 1 vs -1 (in_sum=2, V=0) -> out_result=0.
REQ-036 Backpressure: out_ready=0, offer beats A, B, C back to back -> A and B accepted; in_ready=0 from the edge after B; C held. Then out_ready=1 -> output order A, B, C with no bubble between A and B.
REQ-037 Flush with main and skid full plus in_valid=1 on the same edge -> out_valid=0 and in_ready=1 next cycle; the offered beat never appears at the output.
REQ-038 rst_n=0 for 1 cycle mid-stream with both entries full -> all outputs at reset values next cycle; a beat offered on the first edge after release appears with 1-cycle latency.
